result_writeback: RTL and testbench

Drains the 8x8 systolic-array result matrix back into memory after a multiply completes. On `start`, normally the multiplier's DONE pulse, it snapshots all 64 16-bit C results. It then writes them as byte beats into the 8-bit write port of the two-port RAM, starting at a programmable base address. It is the writer-side counterpart of the controller that reads matrices A and B from the same RAM into the row and column FIFOs.

---
 rtl/xlr8_pkg.sv | 8 +
 rtl/result_writeback_if.sv | 9 +
 rtl/result_snapshot.sv | 19 +
 rtl/result_writeback.sv | 87 ++++++++
 tb/tb_result_writeback.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/xlr8_pkg.sv
// xlr8_pkg: shared accelerator constants and the result writeback FSM states.
package xlr8_pkg;
  localparam int N = 8;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int WB_BEATS = 2 * N * N;
  typedef enum logic [1:0] {WB_IDLE, WB_WRITE, WB_DONE} wb_state_t;
endpackage

// File: rtl/result_writeback_if.sv
// result_writeback_if: byte-wide RAM write port with valid/ready handshake.
interface result_writeback_if #(parameter int ADDR_W = xlr8_pkg::ADDR_W);
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wd;
  logic              mem_ready;
  modport master (output mem_wen, mem_addr, mem_wd, input mem_ready);
  modport slave  (input mem_wen, mem_addr, mem_wd, output mem_ready);
endinterface

// File: rtl/result_snapshot.sv
// result_snapshot: N*N result bank loaded in one cycle, read back one byte at a time.
module result_snapshot #(
  parameter int N = xlr8_pkg::N,
  parameter int DATA_W = xlr8_pkg::DATA_W,
  localparam int BW = $clog2(2 * N * N)
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic [N*N*DATA_W-1:0] c_flat,
  input  logic [BW-1:0]         beat,
  output logic [7:0]            rd_byte
);
  logic [DATA_W-1:0] bank [N*N];
  always_ff @(posedge clk)
    if (load)
      for (int i = 0; i < N * N; i++) bank[i] <= c_flat[i*DATA_W +: DATA_W];
  // beat = {element index, byte select}
  assign rd_byte = bank[beat[BW-1:1]][{beat[0], 3'b000} +: 8];
endmodule

// File: rtl/result_writeback.sv
// result_writeback: drains a snapshotted N*N result matrix into RAM as byte beats.
// Define WB_CHECKSUM_EN to build the running byte-sum on checksum; otherwise it is 0.
module result_writeback #(
  parameter int N = xlr8_pkg::N,
  parameter int DATA_W = xlr8_pkg::DATA_W,
  parameter int ADDR_W = xlr8_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     addr_mtxC,
  input  logic [N*N*DATA_W-1:0] c_flat,
  result_writeback_if.master    mem,
  output logic                  busy,
  output logic                  wb_done,
  output logic [15:0]           checksum
);
  import xlr8_pkg::*;
  localparam int BW = $clog2(2 * N * N);
  wb_state_t         state;
  logic [ADDR_W-1:0] base;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     nxt;
  logic [7:0]        rd_byte;
  logic              load;
  logic              accept;
  logic              last;
  assign load   = state == WB_IDLE && start;
  assign accept = mem.mem_wen && mem.mem_ready;
  assign nxt    = beat + 1'b1;
  assign last   = beat == BW'(2 * N * N - 1);
  result_snapshot #(.N(N), .DATA_W(DATA_W)) u_snap (
    .clk(clk), .load(load), .c_flat(c_flat), .beat(nxt), .rd_byte(rd_byte)
  );
  // Address/data are registered one beat ahead so they hold steady through stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= WB_IDLE;
      base         <= '0;
      beat         <= '0;
      mem.mem_wen  <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wd   <= '0;
      busy         <= 1'b0;
      wb_done      <= 1'b0;
    end else begin
      case (state)
        WB_IDLE:
          if (start) begin
            state        <= WB_WRITE;
            base         <= addr_mtxC;
            beat         <= '0;
            mem.mem_wen  <= 1'b1;
            mem.mem_addr <= addr_mtxC;
            mem.mem_wd   <= c_flat[7:0];
            busy         <= 1'b1;
          end
        WB_WRITE:
          if (accept) begin
            beat         <= nxt;
            mem.mem_addr <= base + ADDR_W'(nxt);
            mem.mem_wd   <= rd_byte;
            if (last) begin
              state       <= WB_DONE;
              mem.mem_wen <= 1'b0;
              busy        <= 1'b0;
              wb_done     <= 1'b1;
            end
          end
        WB_DONE: begin
          state   <= WB_IDLE;
          wb_done <= 1'b0;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end
`ifdef WB_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) checksum <= '0;
    else if (load) checksum <= '0;
    else if (accept) checksum <= checksum + 16'(mem.mem_wd);
  end
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: scoreboard bench for result_writeback with a RAM model.
module tb_result_writeback;
  localparam int N = 8, DW = 16, AW = 10;
  typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} beat_t;
  logic clk = 0, rst = 0, start = 0;
  logic [AW-1:0] addr_mtxC = '0;
  logic [N*N*DW-1:0] c_flat = '0;
  logic busy, wb_done;
  logic [15:0] checksum;
  result_writeback_if #(.ADDR_W(AW)) mem();
  result_writeback dut (
    .clk(clk), .rst(rst), .start(start), .addr_mtxC(addr_mtxC), .c_flat(c_flat),
    .mem(mem), .busy(busy), .wb_done(wb_done), .checksum(checksum)
  );
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, failures = 0, dones = 0;
  beat_t sb[$];
  beat_t mon_e;
  logic [7:0] ram [1<<AW];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst && mem.mem_wen && mem.mem_ready) ram[mem.mem_addr] <= mem.mem_wd;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && wb_done) dones++;
    if (rst && mem.mem_wen) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_extra act=%0h/%0h exp=none", mem.mem_addr, mem.mem_wd);
      end else begin
        mon_e = sb[0];
        chk(mem.mem_ready ? "beat" : "stall_hold", {mem.mem_addr, mem.mem_wd}, {mon_e.a, mon_e.d});
        if (mem.mem_ready) void'(sb.pop_front());
      end
    end
  end
  function automatic logic [N*N*DW-1:0] mk(input int mode);
    logic [N*N*DW-1:0] v;
    for (int e = 0; e < N * N; e++)
      v[e*DW +: DW] = mode == 0 ? DW'(256 * (e / N) + (e % N)) :
                      mode == 1 ? {8'(2 * e + 1), 8'(2 * e)} :
                      mode == 2 ? 16'h0203 : (16'hBEEF ^ DW'(e));
    return v;
  endfunction
  task automatic push(input logic [AW-1:0] b, input logic [N*N*DW-1:0] cf);
    for (int k = 0; k < 2 * N * N; k++) sb.push_back('{a: b + AW'(k), d: cf[k*8 +: 8]});
  endtask
  task automatic run(input logic [AW-1:0] b, input logic [N*N*DW-1:0] cf, input bit alt,
                     input int inj_k, input int rst_k, output int lat);
    int t0;
    addr_mtxC = b;
    c_flat = cf;
    start = 1;
    mem.mem_ready = 1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 0;
    lat = -1;
    for (int k = 0; k < 600 && lat < 0; k++) begin
      if (k == rst_k) begin
        rst = 0;
        #1;
        chk("rst_async", {busy, wb_done, mem.mem_wen, mem.mem_addr, mem.mem_wd, checksum}, '0);
        sb.delete();
        return;
      end
      mem.mem_ready = alt ? (k % 2 == 0) : 1'b1;
      start = (k == inj_k);
      if (k == inj_k) begin
        addr_mtxC = 10'h380;
        c_flat = mk(3);
      end
      @(negedge clk);
      if (k == 0) chk("busy_on", {busy, mem.mem_wen}, 2'b11);
      if (wb_done) begin
        lat = cyc + 1 - t0;
        chk("done_idle", {busy, mem.mem_wen}, 2'b00);
      end
      @(posedge clk); #1;
    end
    start = 0;
    mem.mem_ready = 1;
  endtask
  initial begin
    int lat, d0;
    mem.mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vals", {busy, wb_done, mem.mem_wen, mem.mem_addr, mem.mem_wd, checksum}, '0);
    rst = 1;
    @(posedge clk); #1;
    push(10'h100, mk(0));
    run(10'h100, mk(0), 0, -1, -1, lat);
    chk("basic_lat", lat, 129);
    chk("basic_sb_empty", sb.size(), 0);
    chk("ram_102", ram[10'h102], 8'h01);
    chk("ram_111", ram[10'h111], 8'h01);
    chk("ram_17f", ram[10'h17F], 8'h07);
    push(10'h200, mk(0));
    run(10'h200, mk(0), 1, -1, -1, lat);
    chk("bp_lat", lat, 256);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_ram_202", ram[10'h202], 8'h01);
    chk("bp_ram_211", ram[10'h211], 8'h01);
    push(10'h3F0, mk(1));
    run(10'h3F0, mk(1), 0, -1, -1, lat);
    chk("wrap_lat", lat, 129);
    chk("wrap_ram_000", ram[10'h000], 8'h10);
    chk("wrap_ram_06f", ram[10'h06F], 8'h7F);
    chk("wrap_ram_3f0", ram[10'h3F0], 8'h00);
    d0 = dones;
    push(10'h180, mk(0));
    run(10'h180, mk(0), 0, 40, -1, lat);
    repeat (5) @(posedge clk);
    #1;
    chk("ign_lat", lat, 129);
    chk("ign_one_done", dones - d0, 1);
    chk("ign_sb_empty", sb.size(), 0);
    chk("ign_ram_1ff", ram[10'h1FF], 8'h07);
    push(10'h280, mk(3));
    run(10'h280, mk(3), 0, -1, 50, lat);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("post_rst_idle", {busy, wb_done, mem.mem_wen}, 3'b000);
    push(10'h300, mk(0));
    run(10'h300, mk(0), 0, -1, -1, lat);
    chk("restart_lat", lat, 129);
    chk("restart_sb_empty", sb.size(), 0);
    chk("restart_ram_302", ram[10'h302], 8'h01);
    push(10'h080, mk(2));
    run(10'h080, mk(2), 0, -1, -1, lat);
    chk("cs_lat", lat, 129);
`ifdef WB_CHECKSUM_EN
    chk("checksum", checksum, 16'h0140);
    repeat (3) @(posedge clk);
    #1;
    chk("checksum_hold", checksum, 16'h0140);
`else
    chk("checksum_off", checksum, 16'h0000);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
